// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the MIPS execute stage (ALU op codes, execute
// FSM states, datapath width). The decoder uses the same op encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  // alucontrol encoding
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SRA = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_t;

  function automatic logic is_shift_op(input alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter: one-bit-per-cycle shifter for the execute stage.
// Ports:
//   clk, resetn   clock, async active-low reset
//   flush         abandons the shift in progress
//   start         load din/shamt/op (one-cycle pulse from the FSM)
//   op            sll / srl / sra
//   din, shamt    operand and shift amount
//   run           FSM is in its SHIFT state; advance one bit per cycle
//   done          last step this cycle (count == 1); dout is the final value
//   dout          accumulator after this cycle's step
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             start,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic             run,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [SHW-1:0]   cnt;
  alu_op_t          op_q;
  logic             fill;

  // Right shifts fill with the sign only for sra; sll always fills 0.
  assign fill    = (op_q == ALU_SRA) & acc[WIDTH-1];
  assign acc_nxt = (op_q == ALU_SLL) ? {acc[WIDTH-2:0], 1'b0}
                                     : {fill, acc[WIDTH-1:1]};
  assign done    = run && (cnt == SHW'(1));
  assign dout    = acc_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc  <= '0;
      cnt  <= '0;
      op_q <= ALU_SLL;
    end else if (flush) begin
      cnt  <= '0;
    end else if (start) begin
      acc  <= din;
      cnt  <= shamt;
      op_q <= op;
    end else if (run && (cnt != '0)) begin
      acc  <= acc_nxt;
      cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with valid/ready on both sides and a held
// output register. and/or/add/sub/slt complete on the accepting edge;
// shifts run one bit per cycle through alu_serial_shifter.
// Build option: ALU_EXEC_FAST_SHIFT_EN replaces the serial shifter and the
// SHIFT state with a single-cycle barrel shifter (same results, latency 1).
// Ports:
//   clk, resetn                 clock, async active-low reset
//   flush                       drop in-flight op and held output
//   in_valid/in_ready           operation handshake
//   alucontrol, bitshift,       decoded op; jumpreg is carried as out_jr
//   jumpreg, srca, srcb, shamt
//   out_valid/out_ready         result handshake
//   result, zero, out_jr        registered result, result==0, jr tag
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alucontrol,
  input  logic             bitshift,
  input  logic             jumpreg,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_jr
);

  alu_op_t          op;
  logic             accept;
  logic [WIDTH-1:0] alu_res;

  assign op     = alu_op_t'(alucontrol);
  assign accept = in_valid && in_ready;

`ifdef ALU_EXEC_FAST_SHIFT_EN

  assign in_ready = (!out_valid || out_ready) && !flush;

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_AND: alu_res = srca & srcb;
      ALU_OR:  alu_res = srca | srcb;
      ALU_ADD: alu_res = srca + srcb;
      ALU_SUB: alu_res = srca - srcb;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
      ALU_SLL: alu_res = srcb << shamt;
      ALU_SRL: alu_res = srcb >> shamt;
      ALU_SRA: alu_res = $signed(srcb) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      out_jr    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      zero      <= (alu_res == '0);
      out_jr    <= jumpreg;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`else

  alu_state_t       state;
  logic             long_shift;
  logic             sh_start;
  logic             sh_done;
  logic [WIDTH-1:0] sh_dout;
  logic             jr_pend;

  assign in_ready   = (state == ST_IDLE) && (!out_valid || out_ready) && !flush;
  // Only a real shift with a nonzero amount needs the serial path;
  // shamt==0 is just srcb and completes like any single-cycle op.
  assign long_shift = bitshift && is_shift_op(op) && (shamt != '0);
  assign sh_start   = accept && long_shift;

  // Shift codes reaching this path have a zero amount (or are not flagged
  // as shifts), so the value is simply srcb.
  always_comb begin
    alu_res = '0;
    case (op)
      ALU_AND: alu_res = srca & srcb;
      ALU_OR:  alu_res = srca | srcb;
      ALU_ADD: alu_res = srca + srcb;
      ALU_SUB: alu_res = srca - srcb;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
      default: alu_res = srcb;
    endcase
  end

  alu_serial_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .start  (sh_start),
    .op     (op),
    .din    (srcb),
    .shamt  (shamt),
    .run    (state == ST_SHIFT),
    .done   (sh_done),
    .dout   (sh_dout)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      out_jr    <= 1'b0;
      jr_pend   <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && long_shift) begin
            // accept implies any held output was taken this edge
            state     <= ST_SHIFT;
            out_valid <= 1'b0;
            jr_pend   <= jumpreg;
          end else if (accept) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            zero      <= (alu_res == '0);
            out_jr    <= jumpreg;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (sh_done) begin
            state     <= ST_IDLE;
            out_valid <= 1'b1;
            result    <= sh_dout;
            zero      <= (sh_dout == '0);
            out_jr    <= jr_pend;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready;
  logic [2:0]  alucontrol;
  logic        bitshift, jumpreg;
  logic [31:0] srca, srcb;
  logic [4:0]  shamt;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        zero, out_jr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_exec dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .bitshift(bitshift), .jumpreg(jumpreg),
    .srca(srca), .srcb(srcb), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .out_jr(out_jr)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, b,
                       input logic [4:0] sh, input logic bs, jr);
    in_valid = 1'b1; alucontrol = op; srca = a; srcb = b;
    shamt = sh; bitshift = bs; jumpreg = jr;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, b,
                       input logic [4:0] sh, input logic bs, jr);
    drive(op, a, b, sh, bs, jr);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alucontrol = 3'b000; bitshift = 1'b0; jumpreg = 1'b0;
    srca = '0; srcb = '0; shamt = '0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (zero !== 1'b0 || out_jr !== 1'b0) begin errors++; $display("FAIL reset_zero_jr: got %b%b want 00", zero, out_jr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick(); resetn = 1'b1; tick();
  endtask

  task automatic test_addsub();
    drive(3'b010, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
    tick(); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'h8000_0000) begin errors++; $display("FAIL add_result: got v=%b %h want v=1 80000000", out_valid, result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero: got %b want 0", zero); end
    issue(3'b011, 32'd5, 32'd5, 5'd0, 1'b0, 1'b0);
    checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL sub_zero: got %h z=%b want 0 z=1", result, zero); end
  endtask

  task automatic test_logic();
    issue(3'b111, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0, 1'b0);
    checks++; if (result !== 32'h1 || zero !== 1'b0) begin errors++; $display("FAIL slt_signed: got %h z=%b want 1 z=0", result, zero); end
    issue(3'b001, 32'h0000_F0F0, 32'h0000_0F0F, 5'd0, 1'b0, 1'b0);
    checks++; if (result !== 32'h0000_FFFF) begin errors++; $display("FAIL or: got %h want 0000ffff", result); end
    issue(3'b000, 32'h0000_F0F0, 32'h0000_0F0F, 5'd0, 1'b0, 1'b0);
    checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL and: got %h z=%b want 0 z=1", result, zero); end
  endtask

  // Result must appear exactly sh edges after the accepting edge (same
  // edge when sh==0), with out_valid low and in_ready low until then.
  task automatic run_shift(input string name, input logic [2:0] op,
                           input logic [31:0] b, input logic [4:0] sh,
                           input logic [31:0] exp);
    int bad;
    bad = 0;
    issue(op, 32'hDEAD_BEEF, b, sh, 1'b1, 1'b0);
    for (int k = 0; k < int'(sh); k++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL %s_busy: got %0d busy cycles wrong want 0", name, bad); end
    checks++; if (out_valid !== 1'b1 || result !== exp) begin errors++; $display("FAIL %s_result: got v=%b %h want v=1 %h", name, out_valid, result, exp); end
  endtask

  task automatic test_shift();
    run_shift("sra31", 3'b110, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_shift("srl31", 3'b101, 32'h8000_0000, 5'd31, 32'h0000_0001);
    run_shift("sll0",  3'b100, 32'h1234_5678, 5'd0,  32'h1234_5678);
    run_shift("sll4",  3'b100, 32'h0000_000F, 5'd4,  32'h0000_00F0);
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    tick();                                   // drain the held shift result
    out_ready = 1'b0;
    issue(3'b010, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || result !== 32'd3) begin errors++; $display("FAIL bp_first: got v=%b %0d want v=1 3", out_valid, result); end
    drive(3'b010, 32'd10, 32'd20, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'd3) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || result !== 32'd30) begin errors++; $display("FAIL bp_second: got v=%b %0d want v=1 30", out_valid, result); end
    drive(3'b011, 32'd100, 32'd1, 5'd0, 1'b0, 1'b0);
    tick(); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd99) begin errors++; $display("FAIL bp_third: got v=%b %0d want v=1 99", out_valid, result); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_jr();
    issue(3'b010, 32'h0040_0020, 32'h0, 5'd0, 1'b0, 1'b1);
    checks++; if (out_jr !== 1'b1 || result !== 32'h0040_0020) begin errors++; $display("FAIL jr_tag: got jr=%b %h want jr=1 00400020", out_jr, result); end
    issue(3'b001, 32'h0000_00A5, 32'h0, 5'd0, 1'b0, 1'b0);
    checks++; if (out_jr !== 1'b0 || result !== 32'h0000_00A5) begin errors++; $display("FAIL jr_clear: got jr=%b %h want jr=0 000000a5", out_jr, result); end
  endtask

  task automatic test_flush();
    int bad;
    bad = 0;
    issue(3'b100, 32'h0, 32'h1, 5'd20, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL flush_no_output: got %0d valid cycles want 0", bad); end
  endtask

  task automatic test_reset_mid_shift();
    int bad;
    bad = 0;
    issue(3'b100, 32'h0, 32'h3, 5'd20, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    resetn = 1'b0; #2;
    checks++; if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b0 || out_jr !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got v=%b %h z=%b jr=%b want all 0", out_valid, result, zero, out_jr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    tick(); resetn = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_no_output: got %0d valid cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_logic();
    test_shift();
    test_back_to_back();
    test_jr();
    test_flush();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
